// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU codes: the sequencer state consumed by the control decoder.
package codes;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC1 = 2'd1,
      EXEC2 = 2'd2,
      HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/cpu_sequencer_stall_watchdog.sv
// Stall watchdog: counts consecutive held edges and fires a one-cycle
// expire pulse when the run of stalls reaches TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module stall_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic hold,
   output logic expire,
   output logic timeout_o
);

   localparam int unsigned CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic        EN    = (TIMEOUT_CYCLES > 0);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;

   // Expiry happens on the held edge that would complete the run; the count
   // restarts whenever the hold breaks or the watchdog fires.
   always_comb begin
      expire    = EN & hold & (cnt_q == CW'(LIMIT));
      cnt_d     = cnt_q;
      timeout_d = timeout_q | expire;
      if (!hold || expire) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Stall run counter and sticky timeout flag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle sequencer for the MIPS core: FETCH -> EXEC1 -> EXEC2 per
// instruction, frozen by bus waitrequest or a busy mul/div unit, with a
// sticky HALT on jump-to-zero or watchdog expiry, plus cycle and
// retired-instruction counters.
module cpu_sequencer
   import codes::*;
#(
   parameter int unsigned COUNT_WIDTH    = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   mem_access_i,
   input  logic                   waitrequest_i,
   input  logic                   muldiv_busy_i,
   input  logic                   halt_req_i,
   output state_t                 state_o,
   output logic                   active_o,
   output logic                   stall_o,
   output logic                   timeout_o,
   output logic [COUNT_WIDTH-1:0] cycle_count_o,
   output logic [COUNT_WIDTH-1:0] instr_count_o
);

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [COUNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
   logic                   hold;
   logic                   expire;
   logic                   mem_wait;

   assign mem_wait = mem_access_i & waitrequest_i;

   // Hold condition: bus wait in any active state, mul/div only matters in EXEC2.
   always_comb begin
      hold = 1'b0;
      unique case (state_q)
         FETCH, EXEC1: hold = mem_wait;
         EXEC2:        hold = mem_wait | muldiv_busy_i;
         default:      hold = 1'b0;
      endcase
   end

   stall_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .hold      (hold),
      .expire    (expire),
      .timeout_o (timeout_o)
   );

   // Next state and counters; watchdog expiry outranks holding the state.
   always_comb begin
      state_d     = state_q;
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (state_q != HALT) begin
         cycle_cnt_d = cycle_cnt_q + COUNT_WIDTH'(1);
      end
      if (expire) begin
         state_d = HALT;
      end else if (!hold) begin
         unique case (state_q)
            FETCH: state_d = EXEC1;
            EXEC1: state_d = EXEC2;
            EXEC2: begin
               // halt_req_i only matters on the edge that retires the instruction.
               state_d     = halt_req_i ? HALT : FETCH;
               instr_cnt_d = instr_cnt_q + COUNT_WIDTH'(1);
            end
            default: state_d = HALT;
         endcase
      end
   end

   // State register and counters; reset overrides everything.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= FETCH;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign state_o       = state_q;
   assign active_o      = (state_q != HALT);
   assign stall_o       = hold;
   assign cycle_count_o = cycle_cnt_q;
   assign instr_count_o = instr_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer (watchdog configured for 8 cycles).
module tb_cpu_sequencer;
   import codes::*;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        mem_access_i = 1'b0;
   logic        waitrequest_i = 1'b0;
   logic        muldiv_busy_i = 1'b0;
   logic        halt_req_i = 1'b0;
   state_t      state_o;
   logic        active_o;
   logic        stall_o;
   logic        timeout_o;
   logic [31:0] cycle_count_o;
   logic [31:0] instr_count_o;

   int total = 0;
   int bad   = 0;

   cpu_sequencer #(
      .COUNT_WIDTH(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .mem_access_i  (mem_access_i),
      .waitrequest_i (waitrequest_i),
      .muldiv_busy_i (muldiv_busy_i),
      .halt_req_i    (halt_req_i),
      .state_o       (state_o),
      .active_o      (active_o),
      .stall_o       (stall_o),
      .timeout_o     (timeout_o),
      .cycle_count_o (cycle_count_o),
      .instr_count_o (instr_count_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "bench time limit");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      mem_access_i  = 1'b0;
      waitrequest_i = 1'b0;
      muldiv_busy_i = 1'b0;
      halt_req_i    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (state_o !== FETCH) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_o, FETCH); end
      total++; if (active_o !== 1'b1) begin bad++; $display("FAIL reset_active: got %b want 1", active_o); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
      total++; if (cycle_count_o !== 32'd0) begin bad++; $display("FAIL reset_cycles: got %0d want 0", cycle_count_o); end
      total++; if (instr_count_o !== 32'd0) begin bad++; $display("FAIL reset_instrs: got %0d want 0", instr_count_o); end
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
   endtask

   task automatic test_plain();
      state_t exp_seq [3] = '{FETCH, EXEC1, EXEC2};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         total++; if (state_o !== exp_seq[i % 3]) begin bad++; $display("FAIL plain_state[%0d]: got %0d want %0d", i, state_o, exp_seq[i % 3]); end
         total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL plain_stall[%0d]: got %b want 0", i, stall_o); end
         tick();
      end
      total++; if (instr_count_o !== 32'd3) begin bad++; $display("FAIL plain_instrs: got %0d want 3", instr_count_o); end
      total++; if (cycle_count_o !== 32'd9) begin bad++; $display("FAIL plain_cycles: got %0d want 9", cycle_count_o); end
      total++; if (state_o !== FETCH) begin bad++; $display("FAIL plain_end_state: got %0d want %0d", state_o, FETCH); end
   endtask

   task automatic test_mem_stall();
      do_reset();
      tick();  // now EXEC1, cycle 1
      mem_access_i  = 1'b1;
      waitrequest_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (state_o !== EXEC1) begin bad++; $display("FAIL memstall_state[%0d]: got %0d want %0d", i, state_o, EXEC1); end
         total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL memstall_stall[%0d]: got %b want 1", i, stall_o); end
         tick();
      end
      total++; if (cycle_count_o !== 32'd5) begin bad++; $display("FAIL memstall_cycles: got %0d want 5", cycle_count_o); end
      total++; if (instr_count_o !== 32'd0) begin bad++; $display("FAIL memstall_instrs: got %0d want 0", instr_count_o); end
      idle_inputs();
      #1;
      total++; if (state_o !== EXEC1) begin bad++; $display("FAIL memstall_fifth: got %0d want %0d", state_o, EXEC1); end
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL memstall_release: got %b want 0", stall_o); end
      tick();
      total++; if (state_o !== EXEC2) begin bad++; $display("FAIL memstall_exec2: got %0d want %0d", state_o, EXEC2); end
      tick();
      total++; if (state_o !== FETCH) begin bad++; $display("FAIL memstall_fetch: got %0d want %0d", state_o, FETCH); end
      total++; if (instr_count_o !== 32'd1) begin bad++; $display("FAIL memstall_retire: got %0d want 1", instr_count_o); end
      total++; if (cycle_count_o !== 32'd7) begin bad++; $display("FAIL memstall_cycles_end: got %0d want 7", cycle_count_o); end
   endtask

   task automatic test_halt();
      do_reset();
      halt_req_i = 1'b1;  // asserted through FETCH and EXEC1: must be ignored
      tick();
      tick();
      halt_req_i = 1'b0;
      total++; if (state_o !== EXEC2) begin bad++; $display("FAIL halt_ignored_exec2: got %0d want %0d", state_o, EXEC2); end
      tick();
      total++; if (state_o !== FETCH) begin bad++; $display("FAIL halt_first_retire: got %0d want %0d", state_o, FETCH); end
      tick();
      tick();
      halt_req_i = 1'b1;
      tick();
      halt_req_i = 1'b0;
      total++; if (state_o !== HALT) begin bad++; $display("FAIL halt_state: got %0d want %0d", state_o, HALT); end
      total++; if (active_o !== 1'b0) begin bad++; $display("FAIL halt_active: got %b want 0", active_o); end
      total++; if (instr_count_o !== 32'd2) begin bad++; $display("FAIL halt_instrs: got %0d want 2", instr_count_o); end
      total++; if (cycle_count_o !== 32'd6) begin bad++; $display("FAIL halt_cycles: got %0d want 6", cycle_count_o); end
      mem_access_i  = 1'b1;
      waitrequest_i = 1'b1;
      muldiv_busy_i = 1'b1;
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL halt_stall: got %b want 0", stall_o); end
      for (int i = 0; i < 20; i++) tick();
      total++; if (state_o !== HALT) begin bad++; $display("FAIL halt_sticky: got %0d want %0d", state_o, HALT); end
      total++; if (instr_count_o !== 32'd2) begin bad++; $display("FAIL halt_instrs_frozen: got %0d want 2", instr_count_o); end
      total++; if (cycle_count_o !== 32'd6) begin bad++; $display("FAIL halt_cycles_frozen: got %0d want 6", cycle_count_o); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL halt_no_timeout: got %b want 0", timeout_o); end
      idle_inputs();
   endtask

   task automatic test_muldiv_halt();
      do_reset();
      tick();
      tick();  // EXEC2, cycle 2
      muldiv_busy_i = 1'b1;
      halt_req_i    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (state_o !== EXEC2) begin bad++; $display("FAIL muldiv_state[%0d]: got %0d want %0d", i, state_o, EXEC2); end
         total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL muldiv_stall[%0d]: got %b want 1", i, stall_o); end
         tick();
      end
      muldiv_busy_i = 1'b0;
      #1;
      total++; if (state_o !== EXEC2) begin bad++; $display("FAIL muldiv_fourth: got %0d want %0d", state_o, EXEC2); end
      total++; if (instr_count_o !== 32'd0) begin bad++; $display("FAIL muldiv_no_retire: got %0d want 0", instr_count_o); end
      tick();
      halt_req_i = 1'b0;
      total++; if (state_o !== HALT) begin bad++; $display("FAIL muldiv_halt: got %0d want %0d", state_o, HALT); end
      total++; if (instr_count_o !== 32'd1) begin bad++; $display("FAIL muldiv_instrs: got %0d want 1", instr_count_o); end
      total++; if (cycle_count_o !== 32'd6) begin bad++; $display("FAIL muldiv_cycles: got %0d want 6", cycle_count_o); end
   endtask

   task automatic test_watchdog();
      do_reset();
      mem_access_i  = 1'b1;
      waitrequest_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      total++; if (state_o !== FETCH) begin bad++; $display("FAIL wd_pre_state: got %0d want %0d", state_o, FETCH); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL wd_pre_timeout: got %b want 0", timeout_o); end
      tick();
      total++; if (state_o !== HALT) begin bad++; $display("FAIL wd_state: got %0d want %0d", state_o, HALT); end
      total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL wd_timeout: got %b want 1", timeout_o); end
      total++; if (cycle_count_o !== 32'd8) begin bad++; $display("FAIL wd_cycles: got %0d want 8", cycle_count_o); end
      tick();
      tick();
      total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b want 1", timeout_o); end

      // Reset from a timed-out HALT.
      do_reset();
      total++; if (state_o !== FETCH) begin bad++; $display("FAIL rst_halt_state: got %0d want %0d", state_o, FETCH); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rst_halt_timeout: got %b want 0", timeout_o); end
      total++; if (active_o !== 1'b1) begin bad++; $display("FAIL rst_halt_active: got %b want 1", active_o); end
      total++; if (cycle_count_o !== 32'd0) begin bad++; $display("FAIL rst_halt_cycles: got %0d want 0", cycle_count_o); end

      // Seven held edges, one release, then seven more: no expiry.
      mem_access_i  = 1'b1;
      waitrequest_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      waitrequest_i = 1'b0;
      tick();
      total++; if (state_o !== EXEC1) begin bad++; $display("FAIL wd_drop_advance: got %0d want %0d", state_o, EXEC1); end
      waitrequest_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      total++; if (state_o !== EXEC1) begin bad++; $display("FAIL wd_drop_state: got %0d want %0d", state_o, EXEC1); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL wd_drop_timeout: got %b want 0", timeout_o); end
      tick();
      total++; if (state_o !== HALT) begin bad++; $display("FAIL wd_second_expire: got %0d want %0d", state_o, HALT); end
      total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL wd_second_timeout: got %b want 1", timeout_o); end
      idle_inputs();
   endtask

   task automatic test_reset_stalled_exec2();
      do_reset();
      tick();
      tick();  // EXEC2
      muldiv_busy_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      muldiv_busy_i = 1'b0;
      total++; if (state_o !== FETCH) begin bad++; $display("FAIL rst_exec2_state: got %0d want %0d", state_o, FETCH); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rst_exec2_timeout: got %b want 0", timeout_o); end
      total++; if (active_o !== 1'b1) begin bad++; $display("FAIL rst_exec2_active: got %b want 1", active_o); end
      total++; if (cycle_count_o !== 32'd0) begin bad++; $display("FAIL rst_exec2_cycles: got %0d want 0", cycle_count_o); end
      total++; if (instr_count_o !== 32'd0) begin bad++; $display("FAIL rst_exec2_instrs: got %0d want 0", instr_count_o); end
      // Stall run must have restarted: seven held edges stay below the limit.
      mem_access_i  = 1'b1;
      waitrequest_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      total++; if (state_o !== FETCH) begin bad++; $display("FAIL rst_exec2_wd_state: got %0d want %0d", state_o, FETCH); end
      total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rst_exec2_wd_timeout: got %b want 0", timeout_o); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_plain();
      test_mem_stall();
      test_halt();
      test_muldiv_halt();
      test_watchdog();
      test_reset_stalled_exec2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
